// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the axi_lite_reg_slave register block.
// Signal names follow the Xilinx S_AXI_* naming so block-design connections map one to one.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder with NUM_REGS 32-bit control registers driving fabric logic.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding transaction each.
module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    axi_lite_reg_slave_if.slave      s_axi,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    output logic [1:0]               dbg_wr_state,
    output logic                     dbg_rd_state
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    wr_state_e          wr_state_q, wr_state_d;
    rd_state_e          rd_state_q, rd_state_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic [31:0]        w_data_q, w_data_d;
    logic [3:0]         w_strb_q, w_strb_d;
    logic [31:0]        regs_q [NUM_REGS];
    logic [31:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;

    logic               aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]   c_idx, ar_idx;
    logic [31:0]        c_data;
    logic [3:0]         c_strb;
    logic               unused_bits;

    // A transfer happens on the rising edge where VALID and READY are both high; the master holds
    // VALID and payload until then, and READY here is a registered function of FSM state only.
    assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs   = s_axi.S_AXI_WVALID & wready_q;
    assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
    assign ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        commit     = 1'b0;
        c_idx      = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        c_data     = s_axi.S_AXI_WDATA;
        c_strb     = s_axi.S_AXI_WSTRB;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    aw_idx_d   = c_idx;
                    wr_state_d = W_GOT_AW;
                end else if (w_hs) begin
                    w_data_d   = s_axi.S_AXI_WDATA;
                    w_strb_d   = s_axi.S_AXI_WSTRB;
                    wr_state_d = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_hs) begin
                    c_idx  = aw_idx_q;
                    commit = 1'b1;
                end
            end
            W_GOT_W: begin
                if (aw_hs) begin
                    c_data = w_data_q;
                    c_strb = w_strb_q;
                    commit = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        // Out-of-range indices match no register, so the write is dropped and only SLVERR results.
        if (commit) begin
            wr_state_d = W_RESP;
            bvalid_d   = 1'b1;
            bresp_d    = (32'(c_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (32'(c_idx) == k) begin
                    wr_pulse_d[k] = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (c_strb[b]) regs_d[k][8*b +: 8] = c_data[8*b +: 8];
                    end
                end
            end
        end
        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_GOT_W);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_GOT_AW);
    end

    // Reads sample regs_q before this edge's write lands, giving the pre-write value on a collision.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rvalid_d   = 1'b1;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (32'(ar_idx) == k) begin
                            rdata_d = regs_q[k];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse        = wr_pulse_q;
    assign dbg_wr_state        = wr_state_q;
    assign dbg_rd_state        = rd_state_q;

    genvar gk;
    for (gk = 0; gk < NUM_REGS; gk++) begin : g_reg_out
        assign reg_q[32*gk +: 32] = regs_q[gk];
    end

    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: vector table, hand-written corner sequences and
// randomized traffic against an array-based register model.
module tb_axi_lite_reg_slave;
  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;
  logic [1:0]   dbg_wr_state;
  logic         dbg_rd_state;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] model_regs [4];
  logic [31:0] exp_q[$];

  axi_lite_reg_slave_if #(.ADDR_W(6)) bus ();

  axi_lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(4)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_axi(bus),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse),
    .dbg_wr_state(dbg_wr_state),
    .dbg_rd_state(dbg_rd_state)
  );

  // clock / watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // reference model: registers as an array, byte merge by mask arithmetic
  function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    logic [31:0] mask;
    idx = int'(addr) / 4;
    mask = 32'h0;
    if (idx >= 4) return 2'b10;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [5:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= 4) return {32'h0, 2'b10};
    return {model_regs[idx], 2'b00};
  endfunction

  function automatic logic [127:0] model_packed();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) model_regs[k] = 32'h0;
  endfunction

  // driver tasks
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output logic [3:0] pulse, output bit ok);
    int cyc;
    int held;
    bit aw_done, w_done, aw_fire, w_fire, seen;
    cyc = 0; held = 0; aw_done = 0; w_done = 0; seen = 0; ok = 0;
    resp = 2'b11; pulse = 4'h0;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA = data;
    bus.S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      bus.S_AXI_WVALID = !w_done && (cyc >= w_dly);
      @(negedge ACLK);
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge ACLK); #1;
      aw_done = aw_done | aw_fire;
      w_done = w_done | w_fire;
      cyc++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    if (!(aw_done && w_done)) return;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge ACLK);
      if (bus.S_AXI_BVALID) begin
        if (!seen) begin
          seen = 1;
          resp = bus.S_AXI_BRESP;
          pulse = reg_wr_pulse;
        end
        if (held >= b_dly) begin
          bus.S_AXI_BREADY = 1'b1;
          @(posedge ACLK); #1;
          bus.S_AXI_BREADY = 1'b0;
          ok = 1;
          break;
        end
        held++;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output bit ok);
    int cyc;
    int held;
    bit done, fire, seen;
    cyc = 0; held = 0; done = 0; seen = 0; ok = 0;
    data = 32'h0; resp = 2'b11;
    bus.S_AXI_ARADDR = addr;
    while (!done && cyc < 40) begin
      bus.S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      fire = bus.S_AXI_ARREADY;
      @(posedge ACLK); #1;
      done = fire;
      cyc++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    if (!done) return;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge ACLK);
      if (bus.S_AXI_RVALID) begin
        if (!seen) begin
          seen = 1;
          data = bus.S_AXI_RDATA;
          resp = bus.S_AXI_RRESP;
        end
        if (held >= r_dly) begin
          bus.S_AXI_RREADY = 1'b1;
          @(posedge ACLK); #1;
          bus.S_AXI_RREADY = 1'b0;
          ok = 1;
          break;
        end
        held++;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
  endtask

  task automatic do_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic [3:0] pulse, exp_pulse;
    logic [1:0] mresp;
    bit ok;
    int idx;
    idx = int'(addr) / 4;
    exp_pulse = (idx < 4) ? 4'(1 << idx) : 4'h0;
    mresp = model_write(addr, data, strb);
    axi_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              resp, pulse, ok);
    check({tag, "_done"}, ok, 1);
    check({tag, "_bresp"}, resp, mresp);
    check({tag, "_pulse"}, pulse, exp_pulse);
    check({tag, "_regs"}, reg_q, model_packed());
  endtask

  task automatic do_read(input string tag, input logic [5:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    logic [33:0] m;
    logic [31:0] exp_d;
    bit ok;
    m = model_read(addr);
    exp_q.push_back(m[33:2]);
    axi_read(addr, $urandom_range(0, 2), data, resp, ok);
    exp_d = exp_q.pop_front();
    check({tag, "_done"}, ok, 1);
    check({tag, "_rdata"}, data, exp_d);
    check({tag, "_rresp"}, resp, m[1:0]);
  endtask

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic [1:0] rsp;
    logic [31:0] old;

    vecs[0]  = '{1, 6'h00, 32'h1,        4'hF, 32'h0,        2'b00};
    vecs[1]  = '{1, 6'h04, 32'h2,        4'hF, 32'h0,        2'b00};
    vecs[2]  = '{1, 6'h08, 32'h3,        4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1, 6'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
    vecs[4]  = '{0, 6'h00, 32'h0,        4'h0, 32'h1,        2'b00};
    vecs[5]  = '{0, 6'h04, 32'h0,        4'h0, 32'h2,        2'b00};
    vecs[6]  = '{0, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00};
    vecs[7]  = '{0, 6'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
    vecs[8]  = '{1, 6'h00, 32'h1,        4'hF, 32'h0,        2'b00};
    vecs[9]  = '{1, 6'h00, 32'hAABBCCDD, 4'h2, 32'h0,        2'b00};
    vecs[10] = '{0, 6'h00, 32'h0,        4'h0, 32'h0000CC01, 2'b00};
    vecs[11] = '{1, 6'h10, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10};
    vecs[12] = '{0, 6'h14, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[13] = '{0, 6'h03, 32'h0,        4'h0, 32'h0000CC01, 2'b00};
    vecs[14] = '{1, 6'h07, 32'h12345678, 4'h9, 32'h0,        2'b00};
    vecs[15] = '{0, 6'h04, 32'h0,        4'h0, 32'h12000078, 2'b00};
    vecs[16] = '{1, 6'h08, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};
    vecs[17] = '{0, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00};
    vecs[18] = '{0, 6'h3C, 32'h0,        4'h0, 32'h0,        2'b10};

    // reset block
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    model_reset();
    ARESETN = 1'b0;
    #22;
    check("rst_valid_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                              bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);
    check("rst_resp_data", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 0);
    check("rst_regs", reg_q, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("post_rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
        check($sformatf("vec%0d_tbl_bresp", i), rsp, vecs[i].exp_resp);
      end else begin
        do_read($sformatf("vec%0d", i), vecs[i].addr, rd, rsp);
        check($sformatf("vec%0d_tbl_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_tbl_rresp", i), rsp, vecs[i].exp_resp);
      end
    end

    // AW three cycles ahead of W
    @(posedge ACLK); #1;
    bus.S_AXI_AWADDR = 6'h04;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    check("s2_awready", bus.S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      check($sformatf("s2_got_aw%0d", i), {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}, 3'b010);
      @(posedge ACLK); #1;
    end
    bus.S_AXI_WDATA = 32'h55;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    check("s2_wready", {bus.S_AXI_WREADY, bus.S_AXI_BVALID}, 2'b10);
    @(posedge ACLK); #1;
    bus.S_AXI_WVALID = 1'b0;
    void'(model_write(6'h04, 32'h55, 4'hF));
    @(negedge ACLK);
    check("s2_bvalid", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
    check("s2_pulse", reg_wr_pulse, 4'b0010);
    check("s2_regs", reg_q, model_packed());
    @(negedge ACLK);
    check("s2_pulse_gone", {bus.S_AXI_BVALID, reg_wr_pulse}, 5'b10000);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("s2_b_done", bus.S_AXI_BVALID, 0);

    // BREADY held low for five cycles with the next AW already waiting
    @(posedge ACLK); #1;
    bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    check("s5_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);
    @(posedge ACLK); #1;
    void'(model_write(6'h08, 32'h77, 4'hF));
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_AWADDR = 6'h0C;
    bus.S_AXI_WDATA = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check($sformatf("s5_hold%0d", i), {bus.S_AXI_BVALID, bus.S_AXI_BRESP,
                                         bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 5'b10000);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("s5_after_b", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b011);
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    check("s5_aw_taken", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b01);
    @(posedge ACLK); #1;
    bus.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_WVALID = 1'b0;
    void'(model_write(6'h0C, 32'h99, 4'hF));
    @(negedge ACLK);
    check("s5_second_b", {bus.S_AXI_BVALID, reg_wr_pulse}, 5'b11000);
    check("s5_regs", reg_q, model_packed());
    bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;

    // read and write of the same register on the same edge
    @(posedge ACLK); #1;
    old = model_regs[2];
    bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_WDATA = 32'hCAFE0000; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 6'h08;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    check("rw_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    exp_q.push_back(old);
    void'(model_write(6'h08, 32'hCAFE0000, 4'hF));
    @(negedge ACLK);
    check("rw_valids", {bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 2'b11);
    check("rw_pre_write", bus.S_AXI_RDATA, exp_q.pop_front());
    check("rw_regs", reg_q, model_packed());
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        do_write($sformatf("rnd%0d_w", i), a, $urandom, 4'($urandom_range(0, 15)), rsp);
      else
        do_read($sformatf("rnd%0d_r", i), a, rd, rsp);
    end

    // reset while a read response is pending
    @(posedge ACLK); #1;
    bus.S_AXI_ARADDR = 6'h04;
    bus.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check("s6_rvalid_before", bus.S_AXI_RVALID, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    model_reset();
    check("s6_rvalid_drop", bus.S_AXI_RVALID, 0);
    check("s6_regs_clear", reg_q, model_packed());
    check("s6_ready_clear", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                             bus.S_AXI_BVALID, reg_wr_pulse}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("s6_arready", bus.S_AXI_ARREADY, 1);
    do_read("s6_read", 6'h04, rd, rsp);
    check("s6_read_zero", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
